// File: rtl/sensor_access_scheduler.sv
// Shares one DHT11 transaction engine between host requests and periodic polls.
// Validates each frame, times out stalled reads and holds responses until consumed.
module sensor_access_scheduler #(
  parameter int POLL_PERIOD = 100000000,
  parameter int TIMEOUT     = 5000000,
  parameter int NUM_SENSORS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_command,
  input  logic [7:0]  req_address,
  output logic        eng_enable,
  output logic        eng_reset,
  output logic [7:0]  eng_address,
  input  logic        eng_hold,
  input  logic        eng_error,
  input  logic        eng_data_ok,
  input  logic [39:0] eng_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_command,
  output logic [7:0]  rsp_value,
  output logic [7:0]  rsp_address
);
  // state   | meaning
  // IDLE    | accept a host request, else start the next due poll
  // ISSUE   | present address to the engine, raise enable
  // WAIT    | wait for frame, engine error or timeout
  // RECOVER | drop enable, pulse engine reset
  // RESPOND | hold response until rsp_ready
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RECOVER, RESPOND} state_t;
  typedef enum logic [1:0] {M_OFF, M_TEMP, M_HUM} mode_t;
  typedef enum logic [1:0] {K_STATUS, K_TEMP, K_HUM} kind_t;

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  mode_t                  mode_q [NUM_SENSORS];
  mode_t                  mode_d [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] due_q, due_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [1:0]             rr_q, rr_d;
  kind_t                  kind_q, kind_d;
  logic [7:0]             eng_address_q, eng_address_d;
  logic                   eng_enable_q, eng_enable_d, eng_reset_q, eng_reset_d;
  logic                   req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_cmd_q, rsp_cmd_d, rsp_val_q, rsp_val_d, rsp_addr_q, rsp_addr_d;

  logic       poll_hit;
  logic [1:0] poll_idx;
  logic [1:0] req_idx;
  logic [7:0] sum;
  logic       frame_ok, wait_done;
  logic       imm;
  logic [7:0] imm_cmd, imm_val;
  int         c;

  assign req_idx   = req_address[1:0];
  assign sum       = eng_data[7:0] + eng_data[15:8] + eng_data[23:16] + eng_data[31:24];
  assign frame_ok  = !eng_error && eng_data_ok && !eng_hold && (sum == eng_data[39:32]);
  assign wait_done = eng_error || (eng_data_ok && !eng_hold) || (tmo_q == TMO_LAST);

  // rr_q is the channel the round-robin search starts from
  always_comb begin
    poll_hit = 1'b0;
    poll_idx = '0;
    c        = 0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      c = (int'(rr_q) + k) % NUM_SENSORS;
      if (!poll_hit && due_q[c]) begin
        poll_hit = 1'b1;
        poll_idx = 2'(c);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    due_d         = due_q;
    poll_d        = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
    tmo_d         = tmo_q;
    rr_d          = rr_q;
    kind_d        = kind_q;
    eng_address_d = eng_address_q;
    rsp_cmd_d     = rsp_cmd_q;
    rsp_val_d     = rsp_val_q;
    rsp_addr_d    = rsp_addr_q;
    imm           = 1'b0;
    imm_cmd       = 8'h0F;
    imm_val       = 8'h0F;

    if (poll_q == POLL_LAST)
      for (int i = 0; i < NUM_SENSORS; i++)
        if (mode_q[i] != M_OFF) due_d[i] = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_ready_q && req_valid) begin
          imm    = 1'b1;
          kind_d = K_TEMP;
          if (req_address >= 8'(NUM_SENSORS)) begin
            imm_cmd = 8'hEF;
            imm_val = 8'hEF;
          end else begin
            case (req_command)
              8'h00: begin imm = 1'b0; kind_d = K_STATUS; end
              8'h01: imm = 1'b0;
              8'h02: begin imm = 1'b0; kind_d = K_HUM; end
              8'h03, 8'h04: begin
                if (mode_q[req_idx] == M_OFF) begin
                  imm             = 1'b0;
                  mode_d[req_idx] = (req_command == 8'h03) ? M_TEMP : M_HUM;
                  kind_d          = (req_command == 8'h03) ? K_TEMP : K_HUM;
                end else begin
                  imm_cmd = 8'hFF;
                  imm_val = 8'hFF;
                end
              end
              8'h05, 8'h06: begin
                if (mode_q[req_idx] == ((req_command == 8'h05) ? M_TEMP : M_HUM)) begin
                  mode_d[req_idx] = M_OFF;
                  due_d[req_idx]  = 1'b0;
                  imm_cmd         = (req_command == 8'h05) ? 8'h0A : 8'h0B;
                  imm_val         = 8'h00;
                end else begin
                  imm_cmd = 8'hAA;
                  imm_val = 8'hAA;
                end
              end
              default: ;
            endcase
          end
          rsp_addr_d = req_address;
          if (imm) begin
            state_d   = RESPOND;
            rsp_cmd_d = imm_cmd;
            rsp_val_d = imm_val;
          end else begin
            state_d       = ISSUE;
            eng_address_d = req_address;
          end
        end else if (req_ready_q && poll_hit) begin
          due_d[poll_idx] = 1'b0;
          rr_d            = 2'((int'(poll_idx) + 1) % NUM_SENSORS);
          kind_d          = (mode_q[poll_idx] == M_HUM) ? K_HUM : K_TEMP;
          eng_address_d   = {6'b0, poll_idx};
          rsp_addr_d      = {6'b0, poll_idx};
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (wait_done) begin
          state_d = RECOVER;
          if (!frame_ok) begin
            rsp_cmd_d = 8'h1F;
            rsp_val_d = 8'h1F;
          end else begin
            case (kind_q)
              K_STATUS: begin rsp_cmd_d = 8'h07; rsp_val_d = 8'h07; end
              K_TEMP:   begin rsp_cmd_d = 8'h09; rsp_val_d = eng_data[23:16]; end
              default:  begin rsp_cmd_d = 8'h08; rsp_val_d = eng_data[7:0]; end
            endcase
          end
        end
      end
      RECOVER: state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    eng_enable_d = (state_d == ISSUE) || (state_d == WAIT);
    eng_reset_d  = (state_d == RECOVER);
    req_ready_d  = (state_d == IDLE);
    rsp_valid_d  = (state_d == RESPOND);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < NUM_SENSORS; i++) mode_q[i] <= M_OFF;
      due_q         <= '0;
      poll_q        <= '0;
      tmo_q         <= '0;
      rr_q          <= '0;
      kind_q        <= K_STATUS;
      eng_address_q <= '0;
      eng_enable_q  <= 1'b0;
      eng_reset_q   <= 1'b1;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_cmd_q     <= '0;
      rsp_val_q     <= '0;
      rsp_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      due_q         <= due_d;
      poll_q        <= poll_d;
      tmo_q         <= tmo_d;
      rr_q          <= rr_d;
      kind_q        <= kind_d;
      eng_address_q <= eng_address_d;
      eng_enable_q  <= eng_enable_d;
      eng_reset_q   <= eng_reset_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cmd_q     <= rsp_cmd_d;
      rsp_val_q     <= rsp_val_d;
      rsp_addr_q    <= rsp_addr_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign eng_enable  = eng_enable_q;
  assign eng_reset   = eng_reset_q;
  assign eng_address = eng_address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_command = rsp_cmd_q;
  assign rsp_value   = rsp_val_q;
  assign rsp_address = rsp_addr_q;
endmodule
